// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and sequencer FSM states.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

    // Opcodes 110 and 111 have no ALU function behind them.
    function automatic logic op_illegal(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command and response handshakes between issue logic and the sequencer.
interface alu_op_sequencer_if #(
    parameter int REG_AW = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [REG_AW-1:0] cmd_rs;
    logic [REG_AW-1:0] cmd_rt;
    logic [REG_AW-1:0] cmd_rd;
    logic              cmd_use_imm;
    logic [31:0]       cmd_imm;

    logic              res_valid;
    logic              res_ready;
    logic [31:0]       res_data;
    logic [REG_AW-1:0] res_rd;
    logic              res_err;

    // Issue side: sends commands, consumes responses.
    modport master (
        output cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_use_imm, cmd_imm,
        input  cmd_ready,
        input  res_valid, res_data, res_rd, res_err,
        output res_ready
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_use_imm, cmd_imm,
        output cmd_ready,
        output res_valid, res_data, res_rd, res_err,
        input  res_ready
    );
endinterface

// File: rtl/alu_seq_rf.sv
// Register file: one synchronous write port, three combinational reads, R0 = 0.
module alu_seq_rf #(
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wa_i,
    input  logic [31:0]       wd_i,
    input  logic [REG_AW-1:0] ra_rs_i,
    input  logic [REG_AW-1:0] ra_rt_i,
    input  logic [REG_AW-1:0] ra_dbg_i,
    output logic [31:0]       rd_rs_o,
    output logic [31:0]       rd_rt_o,
    output logic [31:0]       rd_dbg_o
);
    localparam int NREG = 2 ** REG_AW;

    logic [NREG-1:0][31:0] regs_q;

    // Clear everything on reset; writes to R0 are discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd_rs_o  = (ra_rs_i  == '0) ? 32'd0 : regs_q[ra_rs_i];
    assign rd_rt_o  = (ra_rt_i  == '0) ? 32'd0 : regs_q[ra_rt_i];
    assign rd_dbg_o = (ra_dbg_i == '0) ? 32'd0 : regs_q[ra_dbg_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives an external combinational ALU from a register file, one command
// at a time: accept -> execute (1 cycle) -> hold response until taken.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int REG_AW = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_op_sequencer_if.slave    bus,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [2:0]           alu_op,
    input  logic [31:0]          alu_c,
    input  logic [REG_AW-1:0]    dbg_addr,
    output logic [31:0]          dbg_data
);
    seq_state_e        state_q;
    logic              cmd_ready_q;
    logic              res_valid_q;
    logic [31:0]       res_data_q;
    logic [REG_AW-1:0] res_rd_q;
    logic              res_err_q;
    logic [31:0]       alu_a_q;
    logic [31:0]       alu_b_q;
    logic [2:0]        alu_op_q;
    logic [REG_AW-1:0] rd_q;

    logic [31:0] rs_data, rt_data;
    logic        wb_en;

    // Writeback happens on the EXEC->RESP edge, so the next accepted
    // command already reads the updated register.
    assign wb_en = (state_q == ST_EXEC) && !op_illegal(alu_op_q);

    // Operands are read while the command is presented; nothing can write
    // the file between acceptance and EXEC, so this equals an EXEC-time read.
    alu_seq_rf #(.REG_AW(REG_AW)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .we_i     (wb_en),
        .wa_i     (rd_q),
        .wd_i     (alu_c),
        .ra_rs_i  (bus.cmd_rs),
        .ra_rt_i  (bus.cmd_rt),
        .ra_dbg_i (dbg_addr),
        .rd_rs_o  (rs_data),
        .rd_rt_o  (rt_data),
        .rd_dbg_o (dbg_data)
    );

    // Sequencer FSM with registered handshake and ALU-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_err_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rd_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        alu_a_q     <= rs_data;
                        alu_b_q     <= bus.cmd_use_imm ? bus.cmd_imm : rt_data;
                        alu_op_q    <= bus.cmd_op;
                        rd_q        <= bus.cmd_rd;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_data_q  <= op_illegal(alu_op_q) ? 32'd0 : alu_c;
                    res_err_q   <= op_illegal(alu_op_q);
                    res_rd_q    <= rd_q;
                    res_valid_q <= 1'b1;
                    // Quiet the ALU inputs outside EXEC.
                    alu_a_q     <= '0;
                    alu_b_q     <= '0;
                    alu_op_q    <= '0;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_rd    = res_rd_q;
    assign bus.res_err   = res_err_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_op        = alu_op_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a response scoreboard.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [2:0]  alu_op;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    alu_op_sequencer_if #(.REG_AW(3)) bus ();

    alu_op_sequencer #(.REG_AW(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_c    (alu_c),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // Reference combinational ALU; illegal codes return junk so forcing is visible.
    always_comb begin
        alu_c = 32'hDEAD_BEEF;
        case (alu_op)
            3'b000: alu_c = alu_a + alu_b;
            3'b001: alu_c = alu_a - alu_b;
            3'b010: alu_c = alu_a & alu_b;
            3'b011: alu_c = alu_a | alu_b;
            3'b100: alu_c = (alu_b >= 32) ? 32'd0 : (alu_a >> alu_b[4:0]);
            3'b101: alu_c = (alu_b >= 32) ? {32{alu_a[31]}} : 32'($signed(alu_a) >>> alu_b[4:0]);
            default: alu_c = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct {
        logic [31:0] d;
        logic [2:0]  rd;
        logic        e;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted response is checked against the scoreboard head.
    always @(negedge clk) begin
        if (bus.res_valid && bus.res_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("res_data", bus.res_data, e.d);
                chk("res_rd", {29'd0, bus.res_rd}, {29'd0, e.rd});
                chk("res_err", {31'd0, bus.res_err}, {31'd0, e.e});
            end
        end
    end

    task automatic dbg(input logic [2:0] a, input logic [31:0] exp, input string nm);
        dbg_addr = a;
        #1;
        chk(nm, dbg_data, exp);
    endtask

    // Issue one command; checks EXEC-cycle ALU drive and 2-edge latency.
    task automatic send(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input logic ui, input logic [31:0] imm,
                        input logic [31:0] ea, input logic [31:0] eb,
                        input logic [31:0] ed, input logic ee,
                        input bit push, input bit wt);
        int n;
        exp_t e;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_rs = rs; bus.cmd_rt = rt;
        bus.cmd_rd = rd; bus.cmd_use_imm = ui; bus.cmd_imm = imm;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("accept_timeout", 32'd1, 32'd0);
        if (push) begin
            e.d = ed; e.rd = rd; e.e = ee;
            q.push_back(e);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("exec_alu_a", alu_a, ea);
        chk("exec_alu_b", alu_b, eb);
        chk("exec_alu_op", {29'd0, alu_op}, {29'd0, op});
        chk("exec_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        chk("exec_res_valid", {31'd0, bus.res_valid}, 32'd0);
        @(negedge clk);
        chk("resp_res_valid", {31'd0, bus.res_valid}, 32'd1);
        chk("resp_alu_quiet", alu_a | alu_b | {29'd0, alu_op}, 32'd0);
        if (wt) begin
            n = 0;
            while (q.size() != 0 && n < 20) begin @(negedge clk); n++; end
            if (n >= 20) chk("resp_timeout", 32'd1, 32'd0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
        chk({tag, "_res_valid"}, {31'd0, bus.res_valid}, 32'd0);
        chk({tag, "_alu_op"}, {29'd0, alu_op}, 32'd0);
        chk({tag, "_alu_ab"}, alu_a | alu_b, 32'd0);
        for (int i = 0; i < 8; i++) dbg(3'(i), 32'd0, {tag, "_reg_clear"});
    endtask

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rs = '0; bus.cmd_rt = '0;
        bus.cmd_rd = '0; bus.cmd_use_imm = 1'b0; bus.cmd_imm = '0;
        bus.res_ready = 1'b1;
        dbg_addr = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_state("rst");
        chk("rst_res_data", bus.res_data, 32'd0);
        chk("rst_res_rd_err", {28'd0, bus.res_rd, bus.res_err}, 32'd0);

        // Load R1 = 5
        send(3'b000, 3'd0, 3'd0, 3'd1, 1'b1, 32'h5, 32'h0, 32'h5, 32'h5, 1'b0, 1, 1);
        dbg(3'd1, 32'h5, "dbg_r1");

        // R2 = FFFF_FFF0, sub R3 = R1 - R2, then R3 = R3 + 1
        send(3'b000, 3'd0, 3'd0, 3'd2, 1'b1, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b0, 1, 1);
        send(3'b001, 3'd1, 3'd2, 3'd3, 1'b0, 32'h0, 32'h5, 32'hFFFF_FFF0, 32'h15, 1'b0, 1, 1);
        dbg(3'd3, 32'h15, "dbg_r3_sub");
        send(3'b000, 3'd3, 3'd0, 3'd3, 1'b1, 32'h1, 32'h15, 32'h1, 32'h16, 1'b0, 1, 1);
        dbg(3'd3, 32'h16, "dbg_r3_fwd");

        // Shifts of R4 = 8000_0000
        send(3'b000, 3'd0, 3'd0, 3'd4, 1'b1, 32'h8000_0000, 32'h0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1, 1);
        send(3'b101, 3'd4, 3'd0, 3'd6, 1'b1, 32'h4, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, 1, 1);
        send(3'b100, 3'd4, 3'd0, 3'd7, 1'b1, 32'h4, 32'h8000_0000, 32'h4, 32'h0800_0000, 1'b0, 1, 1);
        dbg(3'd6, 32'hF800_0000, "dbg_r6_sra");

        // Illegal opcode leaves R5 alone
        send(3'b000, 3'd0, 3'd0, 3'd5, 1'b1, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1, 1);
        send(3'b110, 3'd1, 3'd2, 3'd5, 1'b0, 32'h0, 32'h5, 32'hFFFF_FFF0, 32'h0, 1'b1, 1, 1);
        dbg(3'd5, 32'h1234_5678, "dbg_r5_illegal");

        // AND into R0: result returned, R0 stays 0
        send(3'b010, 3'd2, 3'd3, 3'd0, 1'b0, 32'h0, 32'hFFFF_FFF0, 32'h16, 32'h10, 1'b0, 1, 1);
        dbg(3'd0, 32'h0, "dbg_r0");

        // Backpressure: hold the response 5 cycles with a competing command present
        bus.res_ready = 1'b0;
        send(3'b011, 3'd1, 3'd3, 3'd1, 1'b0, 32'h0, 32'h5, 32'h16, 32'h17, 1'b0, 1, 0);
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'b000; bus.cmd_rs = 3'd0;
        bus.cmd_rd = 3'd6; bus.cmd_use_imm = 1'b1; bus.cmd_imm = 32'hAA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_res_valid", {31'd0, bus.res_valid}, 32'd1);
            chk("bp_res_data", bus.res_data, 32'h17);
            chk("bp_res_rd", {29'd0, bus.res_rd}, 32'd1);
            chk("bp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        end
        @(posedge clk); #2;
        bus.res_ready = 1'b1;
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("bp_idle_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("bp_q_drained", q.size(), 32'd0);
        @(negedge clk);
        chk("bp_no_second_accept", {31'd0, bus.cmd_ready}, 32'd1);
        dbg(3'd6, 32'hF800_0000, "dbg_r6_not_written");
        dbg(3'd1, 32'h17, "dbg_r1_or");

        // Reset during EXEC
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'b000; bus.cmd_rs = 3'd1;
        bus.cmd_rd = 3'd2; bus.cmd_use_imm = 1'b1; bus.cmd_imm = 32'h1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("rst_exec");

        // Reset during RESP
        send(3'b000, 3'd0, 3'd0, 3'd1, 1'b1, 32'h99, 32'h0, 32'h99, 32'h99, 1'b0, 1, 1);
        dbg(3'd1, 32'h99, "dbg_r1_reload");
        bus.res_ready = 1'b0;
        send(3'b000, 3'd1, 3'd0, 3'd2, 1'b1, 32'h1, 32'h99, 32'h1, 32'h9A, 1'b0, 0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        check_reset_state("rst_resp");
        chk("rst_resp_q_empty", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
